// File: rtl/mips_pkg.sv
// Shared constants for the register-file writeback path: requester ids and the hardwired zero register.
package mips_pkg;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_t;

    localparam int ZERO_REG = 0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector between the ALU and load writeback requesters.
module rr_arb2
    import mips_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    req_id_t last;

    always_comb begin
        gnt_alu = req_alu;
        gnt_mem = req_mem;
        if (req_alu && req_mem) begin
            gnt_alu = (last == REQ_MEM);
            gnt_mem = (last == REQ_ALU);
        end
    end

    // Every grant is an acceptance, so the pointer follows each grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ_MEM;
        end else if (gnt_alu) begin
            last <= REQ_ALU;
        end else if (gnt_mem) begin
            last <= REQ_MEM;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file with a pending-write scoreboard.
// Defining RF_BYPASS_EN adds forwarding outputs q1_hit/q2_hit/q1_data/q2_data.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_reg,
    input  logic [ADDR_W-1:0] q1_reg,
    input  logic [ADDR_W-1:0] q2_reg,
    output logic              q1_busy,
    output logic              q2_busy,
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              rsv_err
`ifdef RF_BYPASS_EN
    ,
    output logic              q1_hit,
    output logic              q2_hit,
    output logic [DATA_W-1:0] q1_data,
    output logic [DATA_W-1:0] q2_data
`endif
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic              gnt_alu;
    logic              gnt_mem;
    logic              acc;
    logic [ADDR_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_data;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   set_mask;
    logic              rsv_conflict;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign acc       = gnt_alu | gnt_mem;
    assign acc_reg   = gnt_alu ? alu_reg  : mem_reg;
    assign acc_data  = gnt_alu ? alu_data : mem_data;

    // Set is applied after clear so a same-edge reservation wins.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (acc) clr_mask[acc_reg] = 1'b1;
        if (rsv_valid) set_mask[rsv_reg] = 1'b1;
        set_mask[ZERO_REG] = 1'b0;
    end

    assign rsv_conflict = rsv_valid && busy[rsv_reg] && !(acc && (acc_reg == rsv_reg));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= '0;
            rsv_err <= 1'b0;
        end else begin
            busy <= (busy & ~clr_mask) | set_mask;
            if (rsv_conflict) rsv_err <= 1'b1;
        end
    end

    // Writes to the zero register are accepted but dropped before the output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            regWrite <= acc && (acc_reg != ZERO_IDX);
            if (acc && (acc_reg != ZERO_IDX)) begin
                writeReg  <= acc_reg;
                writeData <= acc_data;
            end
        end
    end

    assign q1_busy = busy[q1_reg];
    assign q2_busy = busy[q2_reg];

`ifdef RF_BYPASS_EN
    assign q1_hit  = regWrite && (writeReg == q1_reg) && (q1_reg != ZERO_IDX);
    assign q2_hit  = regWrite && (writeReg == q2_reg) && (q2_reg != ZERO_IDX);
    assign q1_data = q1_hit ? writeData : '0;
    assign q2_data = q2_hit ? writeData : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vectors, hand sequences and a randomized model run.
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid, alu_ready;
    logic [ADDR_W-1:0] alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid, mem_ready;
    logic [ADDR_W-1:0] mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              rsv_valid;
    logic [ADDR_W-1:0] rsv_reg;
    logic [ADDR_W-1:0] q1_reg, q2_reg;
    logic              q1_busy, q2_busy;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              rsv_err;
`ifdef RF_BYPASS_EN
    logic              q1_hit, q2_hit;
    logic [DATA_W-1:0] q1_data, q2_data;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_reg   (mem_reg),
        .mem_data  (mem_data),
        .rsv_valid (rsv_valid),
        .rsv_reg   (rsv_reg),
        .q1_reg    (q1_reg),
        .q2_reg    (q2_reg),
        .q1_busy   (q1_busy),
        .q2_busy   (q2_busy),
        .regWrite  (regWrite),
        .writeReg  (writeReg),
        .writeData (writeData),
        .rsv_err   (rsv_err)
`ifdef RF_BYPASS_EN
        ,
        .q1_hit    (q1_hit),
        .q2_hit    (q2_hit),
        .q1_data   (q1_data),
        .q2_data   (q2_data)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
        mem_valid = 1'b0; mem_reg = '0; mem_data = '0;
        rsv_valid = 1'b0; rsv_reg = '0;
    endtask

    typedef struct {
        logic              av;
        logic [ADDR_W-1:0] ar;
        logic [DATA_W-1:0] ad;
        logic              mv;
        logic [ADDR_W-1:0] mr;
        logic [DATA_W-1:0] md;
        logic              e_ar;
        logic              e_mr;
        logic              e_we;
        logic [ADDR_W-1:0] e_wr;
        logic [DATA_W-1:0] e_wd;
    } vec_t;

    vec_t vecs[10];

    // Reference model state: grant history as a requester id, busy set as a bit array.
    int                m_last;   // 1 = ALU, 2 = MEM
    logic [31:0]       m_busy;
    logic              m_err;
    logic              m_we;
    logic [ADDR_W-1:0] m_wr;
    logic [DATA_W-1:0] m_wd;

    initial begin
        int g;
        int clr_idx;

        idle_inputs();
        q1_reg = '0; q2_reg = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_regWrite",  regWrite,  0);
        chk("rst_writeReg",  writeReg,  0);
        chk("rst_writeData", writeData, 0);
        chk("rst_rsv_err",   rsv_err,   0);
        chk("rst_q1_busy",   q1_busy,   0);
        chk("rst_alu_ready", alu_ready, 0);

        // Directed vectors; pointer starts at mem-last so ALU wins first contention.
        vecs[0] = '{1, 1, 'h11,   1, 2, 'h22,   1, 0, 1, 1, 'h11};
        vecs[1] = '{1, 1, 'h11,   1, 2, 'h22,   0, 1, 1, 2, 'h22};
        vecs[2] = '{1, 1, 'h11,   1, 2, 'h22,   1, 0, 1, 1, 'h11};
        vecs[3] = '{1, 1, 'h11,   1, 2, 'h22,   0, 1, 1, 2, 'h22};
        vecs[4] = '{1, 5, 'h1234, 0, 0, 0,      1, 0, 1, 5, 'h1234};
        vecs[5] = '{0, 0, 0,      1, 0, 'hFFFF, 0, 1, 0, 5, 'h1234};
        vecs[6] = '{0, 0, 0,      0, 0, 0,      0, 0, 0, 5, 'h1234};
        vecs[7] = '{1, 6, 'h66,   1, 8, 'h88,   1, 0, 1, 6, 'h66};
        vecs[8] = '{0, 0, 0,      1, 8, 'h88,   0, 1, 1, 8, 'h88};
        vecs[9] = '{1, 6, 'h77,   1, 9, 'h99,   1, 0, 1, 6, 'h77};

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
            mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
            #1;
            chk($sformatf("vec%0d_alu_ready", i), alu_ready, vecs[i].e_ar);
            chk($sformatf("vec%0d_mem_ready", i), mem_ready, vecs[i].e_mr);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_regWrite", i),  regWrite,  vecs[i].e_we);
            chk($sformatf("vec%0d_writeReg", i),  writeReg,  vecs[i].e_wr);
            chk($sformatf("vec%0d_writeData", i), writeData, vecs[i].e_wd);
        end

        // Reservation / clear interaction on register 7.
        @(negedge clk);
        idle_inputs();
        q1_reg = 7;
        rsv_valid = 1'b1; rsv_reg = 7;
        @(posedge clk); #1;
        chk("rsv7_busy", q1_busy, 1);
        @(negedge clk);
        rsv_valid = 1'b1; rsv_reg = 7;
        alu_valid = 1'b1; alu_reg = 7; alu_data = 'h70;
        @(posedge clk); #1;
        chk("rsv7_same_edge_busy", q1_busy, 1);
        chk("rsv7_same_edge_err",  rsv_err, 0);
        @(negedge clk);
        rsv_valid = 1'b0;
        alu_valid = 1'b1; alu_reg = 7; alu_data = 'h71;
        @(posedge clk); #1;
        chk("wr7_clear_busy", q1_busy, 0);

        // Double reservation of register 9 raises a sticky error.
        @(negedge clk);
        idle_inputs();
        q2_reg = 9;
        rsv_valid = 1'b1; rsv_reg = 9;
        @(posedge clk); #1;
        chk("rsv9_first_err", rsv_err, 0);
        @(negedge clk);
        rsv_valid = 1'b1; rsv_reg = 9;
        @(posedge clk); #1;
        chk("rsv9_second_err", rsv_err, 1);
        @(negedge clk);
        rsv_valid = 1'b1; rsv_reg = 12;
        @(posedge clk); #1;
        chk("rsv_err_held", rsv_err, 1);

        // Reset while a write sits in the output stage.
        @(negedge clk);
        idle_inputs();
        q1_reg = 12;
        alu_valid = 1'b1; alu_reg = 4; alu_data = 'hCAFE;
        @(posedge clk); #1;
        chk("midwr_regWrite", regWrite, 1);
        rst_n = 1'b0;
        #1;
        chk("midwr_rst_regWrite", regWrite, 0);
        chk("midwr_rst_busy12",   q1_busy,  0);
        chk("midwr_rst_busy9",    q2_busy,  0);
        chk("midwr_rst_err",      rsv_err,  0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_regWrite", regWrite, 0);

        // Randomized run against the reference model, starting from reset state.
        m_last = 2; m_busy = '0; m_err = 1'b0; m_we = 1'b0; m_wr = '0; m_wd = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            alu_valid = 1'($urandom_range(0, 1));
            mem_valid = 1'($urandom_range(0, 1));
            alu_reg   = ADDR_W'($urandom_range(0, 7));
            mem_reg   = ADDR_W'($urandom_range(0, 7));
            alu_data  = $urandom;
            mem_data  = $urandom;
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_reg   = ADDR_W'($urandom_range(0, 7));
            q1_reg    = ADDR_W'($urandom_range(0, 7));
            q2_reg    = ADDR_W'($urandom_range(0, 7));
            #1;
            if (alu_valid && mem_valid) g = (m_last == 2) ? 1 : 2;
            else if (alu_valid)         g = 1;
            else if (mem_valid)         g = 2;
            else                        g = 0;
            chk("rnd_alu_ready", alu_ready, (g == 1));
            chk("rnd_mem_ready", mem_ready, (g == 2));
            @(posedge clk);
            clr_idx = -1;
            m_we = 1'b0;
            if (g != 0) begin
                m_last  = g;
                clr_idx = (g == 1) ? int'(alu_reg) : int'(mem_reg);
                if (clr_idx != 0) begin
                    m_we = 1'b1;
                    m_wr = ADDR_W'(clr_idx);
                    m_wd = (g == 1) ? alu_data : mem_data;
                end
                m_busy[clr_idx] = 1'b0;
            end
            if (rsv_valid && rsv_reg != 0) begin
                if (m_busy[rsv_reg] == 1'b1 || (clr_idx == int'(rsv_reg))) begin
                    if (clr_idx != int'(rsv_reg)) m_err = 1'b1;
                end
                m_busy[rsv_reg] = 1'b1;
            end
            #1;
            chk("rnd_regWrite",  regWrite,  m_we);
            chk("rnd_writeReg",  writeReg,  m_wr);
            chk("rnd_writeData", writeData, m_wd);
            chk("rnd_rsv_err",   rsv_err,   m_err);
            chk("rnd_q1_busy",   q1_busy,   m_busy[q1_reg]);
            chk("rnd_q2_busy",   q2_busy,   m_busy[q2_reg]);
        end

`ifdef RF_BYPASS_EN
        @(negedge clk);
        idle_inputs();
        alu_valid = 1'b1; alu_reg = 3; alu_data = 'hAA;
        q2_reg = 3;
        @(posedge clk); #1;
        chk("byp_q2_hit",  q2_hit,  1);
        chk("byp_q2_data", q2_data, 'hAA);
        q2_reg = 0;
        #1;
        chk("byp_q2_zero_hit", q2_hit, 0);
`endif

        @(negedge clk);
        idle_inputs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
